// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and repeat-counter width helper for the button conditioner
package button_pkg;
  typedef enum logic [1:0] {BTN_IDLE, BTN_PRESS_WAIT, BTN_HELD, BTN_RELEASE_WAIT} btn_state_t;
  function automatic int rpt_w(input int d, input int r);
    return $clog2((d > r ? d : r) + 1);
  endfunction
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw key inputs and conditioned level/pulse outputs as one bundle
interface button_conditioner_if #(parameter int N_CH = 4);
  logic [N_CH-1:0] Key;
  logic [N_CH-1:0] Level;
  logic [N_CH-1:0] Press;
  logic [N_CH-1:0] Release;
  modport master (output Key, input Level, Press, Release);
  modport slave (input Key, output Level, Press, Release);
endinterface

// File: rtl/button_channel.sv
// button_channel: one button's synchroniser, debounce FSM and level/press/release outputs; BUTTON_REPEAT_EN adds auto-repeat
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16
`ifdef BUTTON_REPEAT_EN
  , parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE = 16
`endif
) (
  input  logic Clock,
  input  logic Reset,
  input  logic p,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic level_q, level_d, press_q, press_d, rel_q, rel_d;
  logic s, rpt_hit;
  assign s = sync_q[SYNC_STAGES-1];
`ifdef BUTTON_REPEAT_EN
  localparam int RW = rpt_w(REPEAT_DELAY, REPEAT_RATE);
  logic [RW-1:0] rpt_q, rpt_d, rpt_nx;
  logic first_q, first_d, stay_held;
  // repeat counter: restart on HELD entry, count while staying HELD, freeze elsewhere
  always_comb begin
    stay_held = state_q == BTN_HELD && state_d == BTN_HELD;
    rpt_nx = rpt_q + RW'(1);
    rpt_hit = stay_held && rpt_nx == (first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE));
    rpt_d = (state_d == BTN_HELD && state_q != BTN_HELD) ? '0 : stay_held ? (rpt_hit ? '0 : rpt_nx) : rpt_q;
    first_d = (state_d == BTN_HELD && state_q != BTN_HELD) ? 1'b1 : rpt_hit ? 1'b0 : first_q;
  end
  // repeat counter registers
  always_ff @(posedge Clock)
    if (Reset) begin
      rpt_q <= '0;
      first_q <= 1'b1;
    end else begin
      rpt_q <= rpt_d;
      first_q <= first_d;
    end
`else
  assign rpt_hit = 1'b0;
`endif
  // synchroniser shift, debounce FSM next state and Moore outputs of the next state
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], p};
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      BTN_IDLE: if (s) begin
        state_d = BTN_PRESS_WAIT;
        cnt_d = CW'(1);
      end
      BTN_PRESS_WAIT: if (!s) begin
        state_d = BTN_IDLE;
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) state_d = BTN_HELD;
      else cnt_d = cnt_inc;
      BTN_HELD: if (!s) begin
        state_d = BTN_RELEASE_WAIT;
        cnt_d = CW'(1);
      end
      default: if (s) begin
        state_d = BTN_HELD;
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) state_d = BTN_IDLE;
      else cnt_d = cnt_inc;
    endcase
    level_d = state_d == BTN_HELD || state_d == BTN_RELEASE_WAIT;
    press_d = (state_q == BTN_PRESS_WAIT && state_d == BTN_HELD) || rpt_hit;
    rel_d = state_q == BTN_RELEASE_WAIT && state_d == BTN_IDLE;
  end
  // state, counter, synchroniser and registered output flops
  always_ff @(posedge Clock)
    if (Reset) begin
      sync_q <= '0;
      state_q <= BTN_IDLE;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q <= rel_d;
    end
  assign level = level_q;
  assign press = press_q;
  assign rel = rel_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_CH independent debounced buttons with level and press/release pulses; BUTTON_REPEAT_EN enables auto-repeat
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW = 1
`ifdef BUTTON_REPEAT_EN
  , parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE = 16
`endif
) (
  input logic Clock,
  input logic Reset,
  button_conditioner_if.slave bus
);
  logic [N_CH-1:0] p, lvl, prs, rls;
  assign p = ACTIVE_LOW ? ~bus.Key : bus.Key;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_REPEAT_EN
      , .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE(REPEAT_RATE)
`endif
    ) u_ch (
      .Clock(Clock),
      .Reset(Reset),
      .p(p[i]),
      .level(lvl[i]),
      .press(prs[i]),
      .rel(rls[i])
    );
  end
  assign bus.Level = lvl;
  assign bus.Press = prs;
  assign bus.Release = rls;
endmodule
